// File: rtl/gsm_cell_free_mgr.sv
// Cell reference counting and round-robin release arbitration feeding a show-ahead free-address FIFO.
// Latency: ack is combinational; a freed address shows on o_hmp_valid/o_hmp_addr and o_bf_free_flag one cycle after the ack.
// Backpressure: requests are held until acked; full FIFO drops pushes; GSM_FREE_MGR_CHK_EN enables the sticky o_err checks.

module gsm_free_fifo #(
    parameter int DW = 7,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic          push_ok,
    output logic [DW-1:0] head_dat,
    output logic [AW:0]   level
);
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem_q [2**AW];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          pop_ok;
    logic          empty;
    logic          full;

    // Extra pointer bit lets full and empty be told apart while the pointers wrap naturally.
    assign level    = wr_ptr_q - rd_ptr_q;
    assign empty    = (level == '0);
    assign full     = (level == FULL_LVL);
    assign pop_ok   = pop && !empty && !clr;
    assign push_ok  = push && !clr && (!full || pop_ok);
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

module gsm_cell_free_mgr #(
    parameter int MWIDTH     = 4,
    parameter int LOG_MWIDTH = 2,
    parameter int AWIDTH     = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     i_alloc_wr_en,
    input  logic [AWIDTH-1:0]        i_alloc_addr,
    input  logic [MWIDTH-1:0]        i_alloc_multicast,
    input  logic [MWIDTH-1:0]        i_rel_req,
    input  logic [MWIDTH*AWIDTH-1:0] i_rel_addr,
    output logic [MWIDTH-1:0]        o_rel_ack,
    input  logic                     i_hmp_rd,
    output logic                     o_hmp_valid,
    output logic [AWIDTH-1:0]        o_hmp_addr,
    output logic                     o_bf_free_flag,
    output logic [AWIDTH:0]          o_free_cnt,
    output logic                     o_err
);
    localparam int                  NCELL = 2**AWIDTH;
    localparam int                  CW    = LOG_MWIDTH + 1;
    localparam logic [LOG_MWIDTH:0] M_L   = (LOG_MWIDTH+1)'(MWIDTH);
    localparam logic [LOG_MWIDTH-1:0] LAST_PORT = LOG_MWIDTH'(MWIDTH - 1);

    logic [CW-1:0]           cnt_q [NCELL];
    logic [LOG_MWIDTH-1:0]   rr_ptr_q;
    logic [LOG_MWIDTH-1:0]   rr_ptr_d;
    logic                    flag_q;

    logic [2*MWIDTH-1:0]     req_dbl;
    logic                    gnt_vld;
    logic [LOG_MWIDTH:0]     gnt_sum;
    logic [LOG_MWIDTH:0]     gnt_wrap;
    logic [LOG_MWIDTH-1:0]   gnt_idx;
    logic [AWIDTH-1:0]       rel_addr;
    logic [CW-1:0]           old_cnt;
    logic [CW-1:0]           alloc_pop;
    logic                    same_addr;
    logic                    rel_dec;
    logic                    rel_push;
    logic                    alloc_push;
    logic                    free_push;
    logic [AWIDTH-1:0]       free_dat;
    logic                    push_ok;

    // Rotate the request vector so the search always starts at the round-robin pointer.
    always_comb begin
        req_dbl = {i_rel_req, i_rel_req} >> rr_ptr_q;
        gnt_vld = 1'b0;
        gnt_sum = '0;
        for (int k = 0; k < MWIDTH; k++) begin
            if (!gnt_vld && req_dbl[k]) begin
                gnt_vld = 1'b1;
                gnt_sum = {1'b0, rr_ptr_q} + (LOG_MWIDTH+1)'(k);
            end
        end
    end

    assign gnt_wrap  = gnt_sum - M_L;
    assign gnt_idx   = (gnt_sum >= M_L) ? gnt_wrap[LOG_MWIDTH-1:0] : gnt_sum[LOG_MWIDTH-1:0];
    assign o_rel_ack = gnt_vld ? (MWIDTH'(1) << gnt_idx) : '0;
    assign rr_ptr_d  = (gnt_idx == LAST_PORT) ? '0 : gnt_idx + LOG_MWIDTH'(1);

    assign rel_addr  = i_rel_addr[gnt_idx*AWIDTH +: AWIDTH];
    assign old_cnt   = cnt_q[rel_addr];

    always_comb begin
        alloc_pop = '0;
        for (int k = 0; k < MWIDTH; k++) begin
            alloc_pop = alloc_pop + CW'(i_alloc_multicast[k]);
        end
    end

    // A release colliding with an allocation of the same cell is ignored; the new count wins.
    assign same_addr  = i_alloc_wr_en && gnt_vld && (i_alloc_addr == rel_addr);
    assign rel_dec    = gnt_vld && !same_addr && (old_cnt != '0);
    assign rel_push   = rel_dec && (old_cnt == CW'(1));
    assign alloc_push = i_alloc_wr_en && (alloc_pop == '0);
    assign free_push  = rel_push || alloc_push;
    assign free_dat   = rel_push ? rel_addr : i_alloc_addr;

    gsm_free_fifo #(
        .DW (AWIDTH),
        .AW (AWIDTH)
    ) u_free_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .push     (free_push),
        .push_dat (free_dat),
        .pop      (i_hmp_rd),
        .push_ok  (push_ok),
        .head_dat (o_hmp_addr),
        .level    (o_free_cnt)
    );

    assign o_hmp_valid    = (o_free_cnt != '0);
    assign o_bf_free_flag = flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            flag_q   <= 1'b0;
            for (int c = 0; c < NCELL; c++) cnt_q[c] <= '0;
        end else if (clr) begin
            rr_ptr_q <= '0;
            flag_q   <= 1'b0;
            for (int c = 0; c < NCELL; c++) cnt_q[c] <= '0;
        end else begin
            if (gnt_vld) rr_ptr_q <= rr_ptr_d;
            flag_q <= push_ok;
            if (rel_dec) cnt_q[rel_addr] <= old_cnt - CW'(1);
            if (i_alloc_wr_en) cnt_q[i_alloc_addr] <= alloc_pop;
        end
    end

`ifdef GSM_FREE_MGR_CHK_EN
    logic err_q;
    logic err_d;
    logic rel_bad;
    logic rd_empty;
    logic push_drop;

    assign rel_bad   = gnt_vld && (same_addr || (old_cnt == '0));
    assign rd_empty  = i_hmp_rd && !o_hmp_valid;
    assign push_drop = free_push && !push_ok;
    assign err_d     = err_q || alloc_push || rel_bad || rd_empty || push_drop
                       || (rel_push && alloc_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_gsm_cell_free_mgr.sv
// Directed and randomized bench for gsm_cell_free_mgr against a queue-based reference model.
module tb_gsm_cell_free_mgr;
    localparam int MW    = 4;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
`ifdef GSM_FREE_MGR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             alloc_wr_en;
    logic [AW-1:0]    alloc_addr;
    logic [MW-1:0]    alloc_mc;
    logic [MW-1:0]    rel_req;
    logic [MW*AW-1:0] rel_addr;
    logic [MW-1:0]    rel_ack;
    logic             hmp_rd;
    logic             hmp_valid;
    logic [AW-1:0]    hmp_addr;
    logic             free_flag;
    logic [AW:0]      free_cnt;
    logic             err;

    gsm_cell_free_mgr #(.MWIDTH(MW), .LOG_MWIDTH(2), .AWIDTH(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clr               (clr),
        .i_alloc_wr_en     (alloc_wr_en),
        .i_alloc_addr      (alloc_addr),
        .i_alloc_multicast (alloc_mc),
        .i_rel_req         (rel_req),
        .i_rel_addr        (rel_addr),
        .o_rel_ack         (rel_ack),
        .i_hmp_rd          (hmp_rd),
        .o_hmp_valid       (hmp_valid),
        .o_hmp_addr        (hmp_addr),
        .o_bf_free_flag    (free_flag),
        .o_free_cnt        (free_cnt),
        .o_err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-cell counts, free list as a queue, arbiter pointer as a port number.
    int ref_cnt [DEPTH];
    int fq [$];
    int rr;
    bit m_err;
    bit m_flag;
    int m_ack;
    logic [MW-1:0] dut_ack;

    bit pend [MW];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (ref_cnt[i]) ref_cnt[i] = 0;
        fq.delete();
        rr = 0;
        m_err = 1'b0;
        m_flag = 1'b0;
    endtask

    task automatic set_idle();
        clr = 1'b0;
        alloc_wr_en = 1'b0;
        alloc_addr = '0;
        alloc_mc = '0;
        rel_req = '0;
        rel_addr = '0;
        hmp_rd = 1'b0;
    endtask

    task automatic set_rel(input int p, input int a);
        rel_req[p] = 1'b1;
        rel_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic do_alloc(input int a, input int mc);
        set_idle();
        alloc_wr_en = 1'b1;
        alloc_addr = AW'(a);
        alloc_mc = MW'(mc);
    endtask

    // Called at a falling edge with inputs already driven; checks, advances the model, ends at the next falling edge.
    task automatic step();
        int g;
        int ra;
        int pc;
        bit rel_push;
        bit alloc_push;
        bit popped;
        #1;
        g = -1;
        for (int i = 0; i < MW; i++) begin
            if (g < 0 && rel_req[(rr + i) % MW]) g = (rr + i) % MW;
        end
        m_ack = (g >= 0) ? (1 << g) : 0;
        dut_ack = rel_ack;
        check_eq("rel_ack", rel_ack, m_ack);
        check_eq("hmp_valid", hmp_valid, fq.size() != 0);
        check_eq("hmp_addr", hmp_addr, (fq.size() != 0) ? fq[0] : 0);
        check_eq("free_cnt", free_cnt, fq.size());
        check_eq("free_flag", free_flag, m_flag);
        check_eq("err", err, m_err && CHK);

        if (clr) begin
            model_reset();
        end else begin
            m_flag = 1'b0;
            rel_push = 1'b0;
            alloc_push = 1'b0;
            popped = 1'b0;
            ra = 0;
            pc = $countones(alloc_mc);
            if (g >= 0) begin
                ra = int'(rel_addr[g*AW +: AW]);
                rr = (g + 1) % MW;
                if (alloc_wr_en && ra == int'(alloc_addr)) m_err = 1'b1;
                else if (ref_cnt[ra] == 0) m_err = 1'b1;
                else begin
                    ref_cnt[ra]--;
                    if (ref_cnt[ra] == 0) rel_push = 1'b1;
                end
            end
            if (alloc_wr_en) begin
                ref_cnt[alloc_addr] = pc;
                if (pc == 0) begin
                    m_err = 1'b1;
                    alloc_push = 1'b1;
                end
            end
            if (hmp_rd) begin
                if (fq.size() == 0) m_err = 1'b1;
                else begin
                    void'(fq.pop_front());
                    popped = 1'b1;
                end
            end
            if (rel_push && alloc_push) m_err = 1'b1;
            if (rel_push || alloc_push) begin
                if (fq.size() == DEPTH) m_err = 1'b1;
                else begin
                    fq.push_back(rel_push ? ra : int'(alloc_addr));
                    m_flag = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then one cell with two destinations released twice.
        step();
        check_eq("rst_free_cnt", free_cnt, 0);
        do_alloc(5, 4'b0110); step();
        set_idle(); set_rel(1, 5); step();
        check_eq("t1_ack_p1", dut_ack, 4'b0010);
        check_eq("t1_no_flag", free_flag, 0);
        set_idle(); set_rel(2, 5); step();
        check_eq("t1_ack_p2", dut_ack, 4'b0100);
        check_eq("t1_flag", free_flag, 1);
        check_eq("t1_valid", hmp_valid, 1);
        check_eq("t1_addr", hmp_addr, 5);
        check_eq("t1_cnt", free_cnt, 1);

        // Four unicast cells released by all ports at once.
        set_idle(); clr = 1'b1; step();
        for (int k = 0; k < 4; k++) begin
            do_alloc(k + 1, 1 << k); step();
        end
        set_idle();
        for (int p = 0; p < 4; p++) set_rel(p, p + 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("t2_ack", dut_ack, 1 << k);
            rel_req = rel_req & ~MW'(m_ack);
        end
        set_idle();
        for (int k = 0; k < 4; k++) begin
            check_eq("t2_pop_addr", hmp_addr, k + 1);
            hmp_rd = 1'b1; step();
        end

        // Two persistent requesters alternate.
        do_alloc(20, 4'b1111); step();
        do_alloc(21, 4'b1111); step();
        set_idle(); set_rel(0, 20); set_rel(3, 21);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("t3_alt", dut_ack, (k % 2) ? 4'b1000 : 4'b0001);
        end

        // Fill the free FIFO, push+pop while full, drain, then one more to cross the pointer wrap.
        set_idle(); clr = 1'b1; step();
        for (int k = 0; k <= DEPTH; k++) begin
            set_idle();
            if (k < DEPTH) begin
                alloc_wr_en = 1'b1; alloc_addr = AW'(k); alloc_mc = 4'b0001;
            end
            if (k > 0) set_rel(0, k - 1);
            step();
        end
        check_eq("t4_full", free_cnt, DEPTH);
        do_alloc(0, 4'b0001); step();
        set_idle(); set_rel(0, 0); hmp_rd = 1'b1; step();
        check_eq("t4_pushpop", free_cnt, DEPTH);
        set_idle(); hmp_rd = 1'b1;
        repeat (DEPTH) step();
        check_eq("t4_empty_valid", hmp_valid, 0);
        check_eq("t4_empty_cnt", free_cnt, 0);
        do_alloc(7, 4'b0001); step();
        set_idle(); set_rel(0, 7); step();
        set_idle();
        check_eq("t4_wrap_valid", hmp_valid, 1);
        check_eq("t4_wrap_addr", hmp_addr, 7);

        // Protocol errors and their clearing.
        clr = 1'b1; step();
        set_idle(); set_rel(0, 9); step();
        check_eq("t5_rel_zero_err", err, CHK);
        check_eq("t5_rel_zero_cnt", free_cnt, 0);
        set_idle(); hmp_rd = 1'b1; step();
        check_eq("t5_pop_empty_err", err, CHK);
        check_eq("t5_pop_empty_cnt", free_cnt, 0);
        set_idle(); clr = 1'b1; step();
        check_eq("t5_clr_err", err, 0);

        // Randomized traffic over a small address range to provoke collisions and reuse.
        for (int p = 0; p < MW; p++) pend[p] = 1'b0;
        set_idle();
        for (int n = 0; n < 3000; n++) begin
            alloc_wr_en = ($urandom_range(0, 3) == 0);
            alloc_addr = AW'($urandom_range(0, 15));
            alloc_mc = MW'($urandom_range(0, 15));
            for (int p = 0; p < MW; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    rel_addr[p*AW +: AW] = AW'($urandom_range(0, 15));
                end
                rel_req[p] = pend[p];
            end
            hmp_rd = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 199) == 0);
            step();
            for (int p = 0; p < MW; p++) if (m_ack[p]) pend[p] = 1'b0;
        end

        // Asynchronous reset while releases are in flight and three addresses are queued.
        set_idle(); clr = 1'b1; step();
        for (int k = 0; k < 3; k++) begin
            do_alloc(30 + k, 4'b0001); step();
        end
        set_idle();
        for (int p = 0; p < 3; p++) set_rel(p, 30 + p);
        for (int k = 0; k < 3; k++) begin
            step();
            rel_req = rel_req & ~MW'(m_ack);
        end
        do_alloc(33, 4'b0011); step();
        set_idle(); set_rel(3, 33); step();
        check_eq("t6_pre_cnt", free_cnt, 3);
        set_idle(); set_rel(1, 33);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_valid", hmp_valid, 0);
        check_eq("t6_async_cnt", free_cnt, 0);
        check_eq("t6_async_addr", hmp_addr, 0);
        check_eq("t6_async_flag", free_flag, 0);
        check_eq("t6_async_err", err, 0);
        model_reset();
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("t6_post_cnt", free_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
